// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one simple DRAM request/response port among NUM_CLIENTS requesters.
//   Requests are arbitrated round-robin. Once a choice is presented to memory
//   and stalls, it stays locked until memory accepts it. Read responses come
//   back in order and are routed to their owner through a FIFO of client-ID
//   tags. One tag is pushed per accepted read.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   cl_req_*        per-client request (valid/write/addr/data in, grant out)
//   cl_resp_*       per-client response valid, shared data bus, per-client grant
//   mem_req_*       request toward memory (valid/write/addr/data out, grant in)
//   mem_resp_*      response from memory (valid/data in, grant out)
//   outstanding     number of reads accepted whose response has not returned
//   err_orphan      sticky flag: memory offered a response with no tag pending
module mem_port_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 512,
  parameter int TAG_DEPTH   = 16,
  localparam int CW = (NUM_CLIENTS > 2) ? $clog2(NUM_CLIENTS) : 1,
  localparam int OW = $clog2(TAG_DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CLIENTS-1:0]        cl_req_valid,
  input  logic [NUM_CLIENTS-1:0]        cl_req_write,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] cl_req_addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] cl_req_data,
  output logic [NUM_CLIENTS-1:0]        cl_req_grant,
  output logic [NUM_CLIENTS-1:0]        cl_resp_valid,
  output logic [DATA_W-1:0]             cl_resp_data,
  input  logic [NUM_CLIENTS-1:0]        cl_resp_grant,
  output logic                          mem_req_valid,
  output logic                          mem_req_write,
  output logic [ADDR_W-1:0]             mem_req_addr,
  output logic [DATA_W-1:0]             mem_req_data,
  input  logic                          mem_req_grant,
  input  logic                          mem_resp_valid,
  input  logic [DATA_W-1:0]             mem_resp_data,
  output logic                          mem_resp_grant,
  output logic [OW-1:0]                 outstanding,
  output logic                          err_orphan
);

  localparam int PW = $clog2(TAG_DEPTH);

  typedef enum logic {ST_ARB, ST_LOCK} state_t;

  state_t          state_reg;
  logic [CW-1:0]   rr_ptr_reg;
  logic [CW-1:0]   lock_sel_reg;
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [OW-1:0]   count_reg;
  logic            err_orphan_reg;
  logic [CW-1:0]   tag_mem [TAG_DEPTH];

  logic [NUM_CLIENTS-1:0] eligible;
  logic [ADDR_W-1:0]      addr_arr [NUM_CLIENTS];
  logic [DATA_W-1:0]      data_arr [NUM_CLIENTS];
  logic [CW-1:0]          arb_sel;
  logic [CW-1:0]          sel;
  logic [CW-1:0]          sel_inc;
  logic [CW-1:0]          head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   req_fire;
  logic                   push;
  logic                   pop;

  // Full is judged on the registered count only, so a pop in the same cycle
  // never makes room for a new read.
  assign fifo_full  = (count_reg == OW'(TAG_DEPTH));
  assign fifo_empty = (count_reg == '0);

  generate
    for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_client
      assign eligible[gi] = cl_req_valid[gi] & (cl_req_write[gi] | ~fifo_full);
      assign addr_arr[gi] = cl_req_addr[gi*ADDR_W +: ADDR_W];
      assign data_arr[gi] = cl_req_data[gi*DATA_W +: DATA_W];
      assign cl_req_grant[gi]  = req_fire & (sel == CW'(gi));
      assign cl_resp_valid[gi] = mem_resp_valid & ~fifo_empty & (head == CW'(gi));
    end
  endgenerate

  // First eligible client at or after rr_ptr, wrapping around.
  always_comb begin
    int unsigned idx;
    logic        found;
    arb_sel = rr_ptr_reg;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      idx = (int'(rr_ptr_reg) + k) % NUM_CLIENTS;
      if (!found && eligible[idx]) begin
        arb_sel = CW'(idx);
        found   = 1'b1;
      end
    end
  end

  // While locked the mux is pinned to the stalled client; no re-arbitration.
  assign sel     = (state_reg == ST_LOCK) ? lock_sel_reg : arb_sel;
  assign sel_inc = (sel == CW'(NUM_CLIENTS - 1)) ? '0 : sel + 1'b1;

  assign mem_req_valid = (state_reg == ST_LOCK) ? eligible[lock_sel_reg] : |eligible;
  assign mem_req_write = cl_req_write[sel];
  assign mem_req_addr  = addr_arr[sel];
  assign mem_req_data  = data_arr[sel];

  assign req_fire = mem_req_valid & mem_req_grant;
  assign push     = req_fire & ~mem_req_write;

  // Responses with no pending tag are held off (grant low), not dropped.
  assign head           = tag_mem[rd_ptr_reg];
  assign cl_resp_data   = mem_resp_data;
  assign mem_resp_grant = mem_resp_valid & ~fifo_empty & cl_resp_grant[head];
  assign pop            = mem_resp_grant;

  assign outstanding = count_reg;
  assign err_orphan  = err_orphan_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_ARB;
      rr_ptr_reg     <= '0;
      lock_sel_reg   <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      err_orphan_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_ARB: begin
          if (mem_req_valid) begin
            if (mem_req_grant) begin
              rr_ptr_reg <= sel_inc;
            end else begin
              state_reg    <= ST_LOCK;
              lock_sel_reg <= arb_sel;
            end
          end
        end
        ST_LOCK: begin
          if (req_fire) begin
            state_reg  <= ST_ARB;
            rr_ptr_reg <= sel_inc;
          end
        end
        default: state_reg <= ST_ARB;
      endcase

      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;

      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase

      if (mem_resp_valid && fifo_empty) err_orphan_reg <= 1'b1;
    end
  end

  // Tag storage carries no reset; validity is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr_reg] <= sel;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int N     = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int OW    = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      cl_req_valid;
  logic [N-1:0]      cl_req_write;
  logic [N*AW-1:0]   cl_req_addr;
  logic [N*DW-1:0]   cl_req_data;
  logic [N-1:0]      cl_req_grant;
  logic [N-1:0]      cl_resp_valid;
  logic [DW-1:0]     cl_resp_data;
  logic [N-1:0]      cl_resp_grant;
  logic              mem_req_valid;
  logic              mem_req_write;
  logic [AW-1:0]     mem_req_addr;
  logic [DW-1:0]     mem_req_data;
  logic              mem_req_grant;
  logic              mem_resp_valid;
  logic [DW-1:0]     mem_resp_data;
  logic              mem_resp_grant;
  logic [OW-1:0]     outstanding;
  logic              err_orphan;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .TAG_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cl_req_valid(cl_req_valid), .cl_req_write(cl_req_write),
    .cl_req_addr(cl_req_addr), .cl_req_data(cl_req_data),
    .cl_req_grant(cl_req_grant), .cl_resp_valid(cl_resp_valid),
    .cl_resp_data(cl_resp_data), .cl_resp_grant(cl_resp_grant),
    .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_req_grant(mem_req_grant), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data), .mem_resp_grant(mem_resp_grant),
    .outstanding(outstanding), .err_orphan(err_orphan)
  );

  // ---------------- behavioural model ----------------
  // Pending reads are a queue of owner IDs; the arbiter is "next owner after
  // the last winner", and a stalled offer is remembered as a pinned client.
  typedef struct {
    int       sel;
    bit       valid;
    bit [N-1:0] grant;
    bit [N-1:0] rvalid;
    bit       rgrant;
  } exp_t;

  int   tagq[$];
  int   rr_m;
  int   pinned_m;
  bit   orphan_m;
  exp_t cmp_e;
  exp_t upd_e;

  function automatic exp_t model_eval();
    exp_t e;
    bit [N-1:0] el;
    e.sel = 0; e.valid = 0; e.grant = '0; e.rvalid = '0; e.rgrant = 0;
    for (int i = 0; i < N; i++)
      el[i] = cl_req_valid[i] && (cl_req_write[i] || tagq.size() < DEPTH);
    if (pinned_m >= 0) begin
      e.sel   = pinned_m;
      e.valid = el[pinned_m];
    end else begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (rr_m + k) % N;
        if (!e.valid && el[j]) begin
          e.sel   = j;
          e.valid = 1;
        end
      end
    end
    if (e.valid && mem_req_grant) e.grant[e.sel] = 1'b1;
    if (tagq.size() > 0 && mem_resp_valid) begin
      e.rvalid[tagq[0]] = 1'b1;
      e.rgrant          = cl_resp_grant[tagq[0]];
    end
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tagq.delete();
      rr_m     = 0;
      pinned_m = -1;
      orphan_m = 0;
    end else begin
      upd_e = model_eval();
      if (mem_resp_valid && tagq.size() == 0) orphan_m = 1;
      if (upd_e.valid && mem_req_grant) begin
        rr_m     = (upd_e.sel + 1) % N;
        pinned_m = -1;
        if (!cl_req_write[upd_e.sel]) tagq.push_back(upd_e.sel);
      end else if (upd_e.valid) begin
        pinned_m = upd_e.sel;
      end
      if (upd_e.rgrant) void'(tagq.pop_front());
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    cmp_e = model_eval();
    chk("mem_req_valid", 64'(mem_req_valid), 64'(cmp_e.valid));
    chk("cl_req_grant", 64'(cl_req_grant), 64'(cmp_e.grant));
    if (cmp_e.valid) begin
      chk("mem_req_addr", 64'(mem_req_addr), 64'(cl_req_addr[cmp_e.sel*AW +: AW]));
      chk("mem_req_data", 64'(mem_req_data), 64'(cl_req_data[cmp_e.sel*DW +: DW]));
      chk("mem_req_write", 64'(mem_req_write), 64'(cl_req_write[cmp_e.sel]));
    end
    chk("cl_resp_valid", 64'(cl_resp_valid), 64'(cmp_e.rvalid));
    chk("mem_resp_grant", 64'(mem_resp_grant), 64'(cmp_e.rgrant));
    chk("cl_resp_data", 64'(cl_resp_data), 64'(mem_resp_data));
    chk("outstanding", 64'(outstanding), 64'(tagq.size()));
    chk("err_orphan", 64'(err_orphan), 64'(orphan_m));
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic set_req(int i, bit v, bit w, logic [AW-1:0] a, logic [DW-1:0] d);
    cl_req_valid[i]            = v;
    cl_req_write[i]            = w;
    cl_req_addr[i*AW +: AW]    = a;
    cl_req_data[i*DW +: DW]    = d;
  endtask

  initial begin
    rst_n = 1'b0;
    cl_req_valid = '0; cl_req_write = '0; cl_req_addr = '0; cl_req_data = '0;
    cl_resp_grant = '0; mem_req_grant = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_data = '0;

    // Reset state
    step();
    at_neg();
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_err_orphan", 64'(err_orphan), 64'd0);
    chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // Four writers, memory always ready: grants rotate 0,1,2,3,0
    mem_req_grant = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1, 1, AW'(32'h1000 + i), DW'(32'hA0 + i));
    for (int k = 0; k < 5; k++) begin
      at_neg();
      chk("rr_grant", 64'(cl_req_grant), 64'(1 << (k % N)));
      step();
    end
    for (int i = 0; i < N; i++) set_req(i, 0, 0, '0, '0);

    // Client 2 issues two reads, responses return to it in order
    set_req(2, 1, 0, 32'h40, '0);
    at_neg();
    chk("rd1_grant", 64'(cl_req_grant), 64'b0100);
    chk("rd1_addr", 64'(mem_req_addr), 64'h40);
    step();
    set_req(2, 1, 0, 32'h80, '0);
    at_neg();
    chk("rd2_grant", 64'(cl_req_grant), 64'b0100);
    chk("rd2_outstanding", 64'(outstanding), 64'd1);
    step();
    set_req(2, 0, 0, '0, '0);
    at_neg();
    chk("rd_outstanding2", 64'(outstanding), 64'd2);
    mem_resp_valid = 1'b1; mem_resp_data = 32'hD1; cl_resp_grant = 4'b0100;
    #1;
    chk("resp1_valid", 64'(cl_resp_valid), 64'b0100);
    chk("resp1_grant", 64'(mem_resp_grant), 64'd1);
    step();
    mem_resp_data = 32'hD2;
    at_neg();
    chk("resp2_outstanding", 64'(outstanding), 64'd1);
    chk("resp2_valid", 64'(cl_resp_valid), 64'b0100);
    step();
    mem_resp_valid = 1'b0; cl_resp_grant = '0;
    at_neg();
    chk("resp_outstanding0", 64'(outstanding), 64'd0);

    // Stalled client 1 stays locked even when client 0 appears
    step();
    mem_req_grant = 1'b0;
    set_req(1, 1, 1, 32'h111, 32'h5);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) set_req(0, 1, 1, 32'h222, 32'h6);
      at_neg();
      chk("lock_addr", 64'(mem_req_addr), 64'h111);
      chk("lock_nogrant", 64'(cl_req_grant), 64'd0);
      step();
    end
    mem_req_grant = 1'b1;
    at_neg();
    chk("lock_grant1", 64'(cl_req_grant), 64'b0010);
    step();
    set_req(1, 0, 0, '0, '0);
    at_neg();
    chk("after_lock_grant0", 64'(cl_req_grant), 64'b0001);
    step();
    set_req(0, 0, 0, '0, '0);

    // Fill the tag FIFO with four reads from client 0
    for (int k = 0; k < DEPTH; k++) begin
      set_req(0, 1, 0, AW'(32'h400 + (k << 6)), '0);
      at_neg();
      chk("fill_grant", 64'(cl_req_grant), 64'b0001);
      step();
    end
    set_req(0, 1, 0, 32'h500, '0);
    at_neg();
    chk("full_outstanding", 64'(outstanding), 64'd4);
    chk("full_blocked", 64'(mem_req_valid), 64'd0);
    step();
    set_req(3, 1, 1, 32'h333, 32'h7);
    at_neg();
    chk("full_write_grant", 64'(cl_req_grant), 64'b1000);
    step();
    set_req(3, 0, 0, '0, '0);
    mem_resp_valid = 1'b1; mem_resp_data = 32'hE0; cl_resp_grant = 4'b0001;
    at_neg();
    chk("pop_same_cycle_blocked", 64'(mem_req_valid), 64'd0);
    chk("pop_grant", 64'(mem_resp_grant), 64'd1);
    step();
    mem_resp_valid = 1'b0; cl_resp_grant = '0;
    at_neg();
    chk("after_pop_read_grant", 64'(cl_req_grant), 64'b0001);
    chk("after_pop_outstanding", 64'(outstanding), 64'd3);
    step();
    set_req(0, 0, 0, '0, '0);
    at_neg();
    chk("refill_outstanding", 64'(outstanding), 64'd4);

    // Head client stalls its response for three cycles
    mem_resp_valid = 1'b1; mem_resp_data = 32'hF0; cl_resp_grant = '0;
    for (int c = 0; c < 3; c++) begin
      step();
      at_neg();
      chk("stall_mem_grant", 64'(mem_resp_grant), 64'd0);
      chk("stall_valid", 64'(cl_resp_valid), 64'b0001);
      chk("stall_data", 64'(cl_resp_data), 64'hF0);
    end
    step();
    cl_resp_grant = 4'b0001;
    for (int k = 0; k < DEPTH; k++) begin
      at_neg();
      chk("drain_grant", 64'(mem_resp_grant), 64'd1);
      step();
    end
    mem_resp_valid = 1'b0; cl_resp_grant = '0;
    at_neg();
    chk("drain_outstanding", 64'(outstanding), 64'd0);

    // Orphan response with empty FIFO
    step();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h99; cl_resp_grant = 4'b1111;
    at_neg();
    chk("orphan_no_valid", 64'(cl_resp_valid), 64'd0);
    chk("orphan_no_grant", 64'(mem_resp_grant), 64'd0);
    step();
    at_neg();
    chk("orphan_set", 64'(err_orphan), 64'd1);
    step();
    mem_resp_valid = 1'b0; cl_resp_grant = '0;
    step();
    at_neg();
    chk("orphan_sticky", 64'(err_orphan), 64'd1);

    // Three reads outstanding, then a reset pulse
    step();
    for (int k = 0; k < 3; k++) begin
      set_req(1, 1, 0, AW'(32'h700 + k), '0);
      step();
    end
    set_req(1, 0, 0, '0, '0);
    at_neg();
    chk("pre_rst_outstanding", 64'(outstanding), 64'd3);
    step();
    rst_n = 1'b0;
    #1;
    chk("async_rst_outstanding", 64'(outstanding), 64'd0);
    chk("async_rst_orphan", 64'(err_orphan), 64'd0);
    step();
    rst_n = 1'b1;
    at_neg();
    chk("post_rst_outstanding", 64'(outstanding), 64'd0);
    step();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h55;
    step();
    at_neg();
    chk("post_rst_orphan", 64'(err_orphan), 64'd1);
    step();
    mem_resp_valid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
